mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single-port unified memory.
// One transaction is outstanding at a time. It moves through IDLE (grant and
// capture), REQ (command held until m_ack) and RESP (wait for m_rvalid or a
// timeout). Grants and responses are combinational pulses in the cycle they
// apply. The m_* command fields come straight from capture registers.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // data port
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  // memory side
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wmask,
  input  logic        m_ack,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  // Sized so that the counter can hold the value TIMEOUT itself.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 2);
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t         state_reg;
  logic           owner_reg;
  logic           last_owner_reg;
  logic           m_we_reg;
  logic [31:0]    m_addr_reg;
  logic [31:0]    m_wdata_reg;
  logic [3:0]     m_wmask_reg;
  logic [CW-1:0]  tmo_cnt_reg;

  logic           any_req;
  logic           sel_owner;
  logic           grant;
  logic           resp_hit;
  logic           tmo_hit;
  logic           done;
  logic [31:0]    resp_data;

  // Arbitration and response decode. Reset masks every pulse in the same cycle.
  always_comb begin
    any_req   = if_req | d_req;
    // On a tie, the requester that was not granted last time wins.
    sel_owner = (if_req && d_req) ? ~last_owner_reg : d_req;
    grant     = !rst && (state_reg == IDLE) && any_req;
    resp_hit  = !rst && (state_reg == RESP) && m_rvalid;
    // A real response in the same cycle takes precedence over the timeout.
    tmo_hit   = !rst && (state_reg == RESP) && !m_rvalid &&
                (tmo_cnt_reg == CW'(TIMEOUT));
    done      = resp_hit | tmo_hit;
    // Stores and timed-out transactions return zero data.
    resp_data = (resp_hit && !m_we_reg) ? m_rdata : 32'd0;

    if_gnt    = grant & (sel_owner == OWN_FETCH);
    d_gnt     = grant & (sel_owner == OWN_DATA);

    if_rvalid = done & (owner_reg == OWN_FETCH);
    d_rvalid  = done & (owner_reg == OWN_DATA);
    if_rdata  = if_rvalid ? resp_data : 32'd0;
    d_rdata   = d_rvalid  ? resp_data : 32'd0;
    if_err    = if_rvalid & tmo_hit;
    d_err     = d_rvalid  & tmo_hit;

    m_req     = !rst && (state_reg == REQ);
    m_we      = m_we_reg;
    m_addr    = m_addr_reg;
    m_wdata   = m_wdata_reg;
    m_wmask   = m_wmask_reg;
  end

  // Transaction FSM: grant/capture, hold the command, await the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_FETCH;
      last_owner_reg <= OWN_FETCH;
      m_we_reg       <= 1'b0;
      m_addr_reg     <= 32'd0;
      m_wdata_reg    <= 32'd0;
      m_wmask_reg    <= 4'd0;
      tmo_cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            owner_reg      <= sel_owner;
            last_owner_reg <= sel_owner;
            if (sel_owner == OWN_DATA) begin
              m_we_reg    <= d_we;
              m_addr_reg  <= d_addr;
              m_wdata_reg <= d_wdata;
              m_wmask_reg <= d_wmask;
            end else begin
              // A fetch is always a plain read.
              m_we_reg    <= 1'b0;
              m_addr_reg  <= if_addr;
              m_wdata_reg <= 32'd0;
              m_wmask_reg <= 4'd0;
            end
            state_reg <= REQ;
          end
        end
        REQ: begin
          if (m_ack) begin
            tmo_cnt_reg <= '0;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (m_rvalid || (tmo_cnt_reg == CW'(TIMEOUT))) begin
            state_reg <= IDLE;
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. It runs three phases:
// a table of directed transactions, a reset-during-response sequence, and
// random transactions. Expected values in the random phase come from a
// transaction-level model.
module tb_mem_arbiter;
  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_wmask;
  logic        m_req, m_we, m_ack, m_rvalid;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wmask;

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wmask(d_wmask), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wmask(m_wmask), .m_ack(m_ack), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // One transaction: requests, expected winner, memory timing and the
  // expected response. rspd > TIMEOUT means the memory never answers.
  typedef struct {
    logic        rb;     // pulse reset before this transaction
    logic        ir;
    logic        dr;
    logic        we;
    logic [31:0] fa;
    logic [31:0] da;
    logic [31:0] wd;
    logic [3:0]  wm;
    int          ackd;   // cycles of m_ack low in REQ
    int          rspd;   // RESP cycle index carrying m_rvalid
    logic [31:0] rd;
    logic        win;    // 0 = fetch, 1 = data
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t tbl [9];

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; m_ack = 1'b1; m_rvalid = 1'b1;
    @(negedge clk);
    chk1("rst_if_gnt", if_gnt, 1'b0);
    chk1("rst_d_gnt", d_gnt, 1'b0);
    chk1("rst_m_req", m_req, 1'b0);
    chk1("rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rst_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    chk1("post_rst_m_req", m_req, 1'b0);
    chk32("post_rst_m_addr", m_addr, 32'd0);
    chk1("post_rst_m_we", m_we, 1'b0);
    chk32("post_rst_m_wdata", m_wdata, 32'd0);
    @(posedge clk); #1;
  endtask

  // Drive one transaction from the IDLE cycle through its response.
  task automatic run_txn(input vec_t v);
    logic [31:0] ea, ew;
    logic [3:0]  em;
    logic        eww;
    if_req = v.ir; if_addr = v.fa;
    d_req = v.dr; d_we = v.we; d_addr = v.da; d_wdata = v.wd; d_wmask = v.wm;
    m_ack = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hBAD0BAD0;  // stray, must be ignored
    @(negedge clk);
    chk1("if_gnt", if_gnt, !v.win);
    chk1("d_gnt", d_gnt, v.win);
    chk1("idle_if_rvalid", if_rvalid, 1'b0);
    chk1("idle_d_rvalid", d_rvalid, 1'b0);
    ea  = v.win ? v.da : v.fa;
    eww = v.win & v.we;
    ew  = v.win ? v.wd : 32'd0;
    em  = v.win ? v.wm : 4'd0;
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    // The winner drops its request and scrambles its fields; the loser holds.
    if (v.win) begin
      d_req = 1'b0; d_we = 1'($urandom_range(0, 1)); d_addr = $urandom;
      d_wdata = $urandom; d_wmask = 4'($urandom_range(0, 15));
    end else begin
      if_req = 1'b0; if_addr = $urandom;
    end
    for (int i = 0; i <= v.ackd; i++) begin
      m_ack = (i == v.ackd);
      @(negedge clk);
      chk1("m_req", m_req, 1'b1);
      chk32("m_addr", m_addr, ea);
      chk1("m_we", m_we, eww);
      chk32("m_wdata", m_wdata, ew);
      chk32("m_wmask", {28'd0, m_wmask}, {28'd0, em});
      chk1("req_no_gnt", if_gnt | d_gnt, 1'b0);
      @(posedge clk); #1;
    end
    m_ack = 1'b0; m_rdata = v.rd;
    for (int k = 0; k <= TIMEOUT; k++) begin
      m_rvalid = (k == v.rspd);
      @(negedge clk);
      if (k == v.rspd || k == TIMEOUT) begin
        chk1("own_rvalid", v.win ? d_rvalid : if_rvalid, 1'b1);
        chk1("oth_rvalid", v.win ? if_rvalid : d_rvalid, 1'b0);
        chk32("own_rdata", v.win ? d_rdata : if_rdata, v.erd);
        chk32("oth_rdata", v.win ? if_rdata : d_rdata, 32'd0);
        chk1("own_err", v.win ? d_err : if_err, v.eerr);
        chk1("oth_err", v.win ? if_err : d_err, 1'b0);
        chk1("resp_m_req", m_req, 1'b0);
        @(posedge clk); #1;
        break;
      end else begin
        chk1("wait_rvalid", if_rvalid | d_rvalid, 1'b0);
        chk1("wait_gnt", if_gnt | d_gnt, 1'b0);
      end
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0; if_req = 1'b0; d_req = 1'b0;
    n_txn++;
    $display("txn %0d: owner=%s addr=%h we=%b ackd=%0d rspd=%0d rdata=%h err=%b",
             n_txn, v.win ? "DATA" : "FETCH", ea, eww, v.ackd, v.rspd, v.erd, v.eerr);
  endtask

  initial begin
    vec_t v;
    logic last;
    int   r;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_addr = '0; d_wdata = '0; d_wmask = '0; m_ack = 1'b0; m_rvalid = 1'b0;
    m_rdata = '0;

    //            rb ir dr we fa           da           wd           wm     ackd rspd rd           win erd          eerr
    tbl[0] = '{1'b1,1'b1,1'b0,1'b0,32'h100,32'h0,32'h0,4'h0,0,0,32'h00500093,1'b0,32'h00500093,1'b0};
    tbl[1] = '{1'b0,1'b0,1'b1,1'b1,32'h0,32'h40,32'hDEADBEEF,4'b0011,0,1,32'h12345678,1'b1,32'h0,1'b0};
    tbl[2] = '{1'b0,1'b1,1'b0,1'b0,32'h104,32'h0,32'h0,4'h0,0,31,32'h55555555,1'b0,32'h0,1'b1};
    tbl[3] = '{1'b0,1'b0,1'b1,1'b0,32'h0,32'h80,32'h0,4'h0,5,2,32'hCAFEF00D,1'b1,32'hCAFEF00D,1'b0};
    tbl[4] = '{1'b0,1'b1,1'b0,1'b0,32'h108,32'h0,32'h0,4'h0,1,TIMEOUT,32'h00000011,1'b0,32'h00000011,1'b0};
    tbl[5] = '{1'b1,1'b1,1'b1,1'b0,32'h300,32'h200,32'h0,4'h0,0,0,32'h0000000A,1'b1,32'h0000000A,1'b0};
    tbl[6] = '{1'b0,1'b1,1'b1,1'b0,32'h304,32'h200,32'h0,4'h0,0,0,32'h0000000B,1'b0,32'h0000000B,1'b0};
    tbl[7] = '{1'b0,1'b1,1'b1,1'b0,32'h308,32'h200,32'h0,4'h0,0,0,32'h0000000C,1'b1,32'h0000000C,1'b0};
    tbl[8] = '{1'b0,1'b1,1'b1,1'b0,32'h30C,32'h200,32'h0,4'h0,0,0,32'h0000000D,1'b0,32'h0000000D,1'b0};

    @(posedge clk); #1;
    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rb) do_reset();
      run_txn(tbl[i]);
    end

    // Reset while in RESP, then a late m_rvalid: no response may appear.
    if_req = 1'b1; if_addr = 32'h500;
    @(negedge clk);
    chk1("rr_if_gnt", if_gnt, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0; m_ack = 1'b1;
    @(negedge clk);
    chk1("rr_m_req", m_req, 1'b1);
    @(posedge clk); #1;
    m_ack = 1'b0; rst = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h77;
    @(negedge clk);
    chk1("rr_rst_if_rvalid", if_rvalid, 1'b0);
    chk1("rr_rst_d_rvalid", d_rvalid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("rr_late_if_rvalid", if_rvalid, 1'b0);
    chk1("rr_late_d_rvalid", d_rvalid, 1'b0);
    chk1("rr_late_m_req", m_req, 1'b0);
    @(posedge clk); #1;
    m_rvalid = 1'b0;
    v = '{1'b0,1'b1,1'b1,1'b0,32'h600,32'h700,32'h0,4'h0,0,1,32'h0000ABCD,1'b1,32'h0000ABCD,1'b0};
    run_txn(v);
    last = 1'b1;

    // Random transactions against the transaction-level model.
    for (int n = 0; n < 150; n++) begin
      v.rb   = 1'b0;
      v.ir   = 1'($urandom_range(0, 1));
      v.dr   = 1'($urandom_range(0, 1));
      if (!v.ir && !v.dr) v.dr = 1'b1;
      v.we   = 1'($urandom_range(0, 1));
      v.fa   = $urandom;
      v.da   = $urandom;
      v.wd   = $urandom;
      v.wm   = 4'($urandom_range(0, 15));
      v.ackd = $urandom_range(0, 3);
      r      = $urandom_range(0, 9);
      v.rspd = (r < 7) ? $urandom_range(0, 4) :
               (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT : TIMEOUT + 5;
      v.rd   = $urandom;
      // Single requester wins outright; on a tie the one not served last wins.
      v.win  = (v.ir && v.dr) ? !last : v.dr;
      last   = v.win;
      v.eerr = (v.rspd > TIMEOUT);
      v.erd  = (v.eerr || (v.win && v.we)) ? 32'd0 : v.rd;
      run_txn(v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
